// File: rtl/instr_fetch_sequencer_if.sv
// Interface bundling the fetch sequencer's PC, instruction-ROM and decode-side signals.
//   master : the fetch sequencer (drives imem_addr, halt, jump, jump_value, instr, instr_valid, done)
//   slave  : the surrounding PC register, ROM and decode stage (drive start, pc, imem_rdata,
//            instr_ready)
interface instr_fetch_sequencer_if #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned JV_W    = 8
);
    logic               start;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               halt;
    logic               jump;
    logic [JV_W-1:0]    jump_value;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               done;

    modport master (
        input  start, pc, imem_rdata, instr_ready,
        output imem_addr, halt, jump, jump_value, instr, instr_valid, done
    );

    modport slave (
        output start, pc, imem_rdata, instr_ready,
        input  imem_addr, halt, jump, jump_value, instr, instr_valid, done
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetch sequencer: presents pc to a sync-read instruction ROM, captures the returned words into
// a small FIFO for decode (valid/ready), and throttles / redirects the PC via halt and jump.
// Ports:
//   clk      : clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : master side of instr_fetch_sequencer_if
//              start, pc, imem_rdata, instr_ready in; imem_addr, halt, jump, jump_value,
//              instr, instr_valid, done out
module instr_fetch_sequencer #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned JV_W    = 8,
    parameter int unsigned DEPTH   = 2,
    parameter logic [2:0]  JUMP_OP = 3'b110,
    parameter logic [2:0]  HALT_OP = 3'b111
) (
    input logic                     clk,
    input logic                     reset_n,
    instr_fetch_sequencer_if.master bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic               inflight_q;
    logic               squash_q;
    logic [JV_W-1:0]    jv_q;

    logic [2:0]         opcode;
    logic [CntW:0]      occupancy;
    logic               halt;
    logic               issue;
    logic               capture;
    logic               pop;
    logic               is_jump;
    logic               is_halt;
    logic [JV_W-1:0]    jump_target;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        opcode      = bus.imem_rdata[INSTR_W-1 -: 3];
        jump_target = JV_W'(bus.imem_rdata[5:0]);

        // Reserve a FIFO slot for every word already in the ROM pipeline so a capture never
        // finds the FIFO full.
        occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
        halt      = (state_q != StFetch) || (occupancy >= (CntW + 1)'(DEPTH));
        issue     = (state_q == StFetch) && !halt && !bus.start;

        capture = inflight_q && !squash_q && !bus.start && (state_q == StFetch);
        is_jump = capture && (opcode == JUMP_OP);
        is_halt = capture && (opcode == HALT_OP);
        pop     = (count_q != '0) && bus.instr_ready;

        count_d = count_q;
        case ({capture, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        if (bus.start) begin
            state_d = StFetch;
        end else if (is_halt) begin
            state_d = StHalted;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            jv_q       <= '0;
        end else if (bus.start) begin
            // Restart flushes everything, including a word still in the ROM pipeline.
            state_q    <= state_d;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= issue;
            // A jump or halt makes the word issued alongside it wrong-path. Only squash when
            // such a word really exists, otherwise the redirected fetch would be discarded.
            squash_q   <= (is_jump || is_halt) && issue;
            if (is_jump) begin
                jv_q <= jump_target;
            end
            if (capture) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Storage needs no reset: contents are only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr   = bus.pc;
    assign bus.halt        = halt;
    assign bus.jump        = is_jump;
    assign bus.jump_value  = is_jump ? jump_target : jv_q;
    assign bus.instr       = mem_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != '0);
    assign bus.done        = (state_q == StHalted) && (count_q == '0);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a behavioural PC register and sync-read ROM.
module tb_instr_fetch_sequencer;

    logic clk;
    logic reset_n;

    instr_fetch_sequencer_if #(.PC_W(16), .INSTR_W(9), .JV_W(8)) bus ();

    instr_fetch_sequencer #(
        .PC_W(16), .INSTR_W(9), .JV_W(8), .DEPTH(2), .JUMP_OP(3'b110), .HALT_OP(3'b111)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    logic [8:0] rom [64];
    logic [8:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;
    int jump_cnt = 0;
    logic [7:0] last_jv = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register: load 0 on start, jump target on jump, otherwise advance unless halted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.pc <= '0;
        end else if (bus.start) begin
            bus.pc <= '0;
        end else if (bus.jump) begin
            bus.pc <= 16'(bus.jump_value);
        end else if (!bus.halt) begin
            bus.pc <= bus.pc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        bus.imem_rdata <= rom[bus.imem_addr[5:0]];
    end

    always @(negedge clk) begin
        if (reset_n && bus.jump) begin
            jump_cnt = jump_cnt + 1;
            last_jv  = bus.jump_value;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_default();
        for (int i = 0; i < 64; i++) rom[i] = 9'(i + 1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Consume words from decode's side and compare them in order against exp_q.
    task automatic expect_words(input string tag, input int budget);
        int idx = 0;
        for (int c = 0; c < budget && idx < exp_q.size(); c++) begin
            if (bus.instr_valid && bus.instr_ready) begin
                check(tag, 32'(bus.instr), 32'(exp_q[idx]));
                idx++;
            end
            tick();
        end
        check({tag, "_count"}, 32'(idx), 32'(exp_q.size()));
    endtask

    initial begin
        rom_default();
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        check("rst_halt", 32'(bus.halt), 32'd1);
        check("rst_jump", 32'(bus.jump), 32'd0);
        check("rst_jv", 32'(bus.jump_value), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: basic stream, first word valid three cycles after the start cycle.
        bus.instr_ready = 1'b1;
        pulse_start();
        check("t1_c1_valid", 32'(bus.instr_valid), 32'd0);
        check("t1_c1_halt", 32'(bus.halt), 32'd0);
        tick();
        check("t1_c2_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        check("t1_c3_valid", 32'(bus.instr_valid), 32'd1);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004};
        expect_words("t1_word", 30);

        // 2: back-pressure holds two words, freezes the PC, then resumes losslessly.
        do_reset();
        bus.instr_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_halt", 32'(bus.halt), 32'd1);
            check("t2_pc", 32'(bus.pc), 32'd2);
            check("t2_head", 32'(bus.instr), 32'h001);
            tick();
        end
        bus.instr_ready = 1'b1;
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
        expect_words("t2_word", 30);

        // 3: jump at ROM[2] to 5; ROM[3] must never reach decode.
        do_reset();
        rom[2] = 9'h185;
        jump_cnt = 0;
        bus.instr_ready = 1'b1;
        pulse_start();
        exp_q = '{9'h001, 9'h002, 9'h185, 9'h006, 9'h007};
        expect_words("t3_word", 30);
        check("t3_jump_cnt", 32'(jump_cnt), 32'd1);
        check("t3_jv", 32'(last_jv), 32'h05);
        check("t3_jv_hold", 32'(bus.jump_value), 32'h05);
        rom_default();

        // 4: halt at ROM[1]; drain to done; restart from pc 0.
        do_reset();
        rom[1] = 9'h1C0;
        bus.instr_ready = 1'b1;
        pulse_start();
        exp_q = '{9'h001, 9'h1C0};
        expect_words("t4_word", 30);
        begin
            int waited = 0;
            while (!bus.done && waited < 20) begin
                tick();
                waited++;
            end
        end
        check("t4_done", 32'(bus.done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t4_halt", 32'(bus.halt), 32'd1);
            check("t4_valid", 32'(bus.instr_valid), 32'd0);
            tick();
        end
        pulse_start();
        check("t4_restart_pc", 32'(bus.pc), 32'd0);
        check("t4_restart_done", 32'(bus.done), 32'd0);
        exp_q = '{9'h001, 9'h1C0};
        expect_words("t4_reword", 30);
        rom_default();

        // 5: asynchronous reset with two words buffered.
        do_reset();
        bus.instr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        check("t5_pre_valid", 32'(bus.instr_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_halt", 32'(bus.halt), 32'd1);
        check("t5_done", 32'(bus.done), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_idle_halt", 32'(bus.halt), 32'd1);
        check("t5_idle_valid", 32'(bus.instr_valid), 32'd0);

        // 6: start while the FIFO is full flushes it and refetches from 0.
        bus.instr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        check("t6_full_valid", 32'(bus.instr_valid), 32'd1);
        check("t6_full_halt", 32'(bus.halt), 32'd1);
        pulse_start();
        check("t6_flush_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_pc", 32'(bus.pc), 32'd0);
        check("t6_halt", 32'(bus.halt), 32'd0);
        bus.instr_ready = 1'b1;
        exp_q = '{9'h001, 9'h002, 9'h003};
        expect_words("t6_word", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
